// File: rtl/stat_report_sched_pkg.sv
// Shared constants, header layout and FSM encoding for the stats report scheduler.
// Report packets use the IOQ module-header format: one header word, data words, one EOP word.
package stat_report_sched_pkg;

    localparam logic [7:0]  IO_QUEUE_STAGE_NUM = 8'hFF;
    localparam logic [7:0]  EOP_CTRL           = 8'h80;
    localparam logic [63:0] PAD_WORD           = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam int HDR_BYTE_LEN_POS = 48;
    localparam int HDR_SRC_POS      = 32;
    localparam int HDR_WORD_LEN_POS = 16;
    localparam int HDR_DST_POS      = 0;

    typedef enum logic [4:0] {
        IDLE     = 5'b00001,
        THRU     = 5'b00010,
        RPT_HDR  = 5'b00100,
        RPT_DATA = 5'b01000,
        RPT_END  = 5'b10000
    } state_t;

    function automatic logic [63:0] make_hdr(input logic [15:0] byte_len,
                                             input logic [15:0] word_len,
                                             input logic [15:0] dst);
        logic [63:0] h;
        h = '0;
        h[HDR_BYTE_LEN_POS +: 16] = byte_len;
        h[HDR_SRC_POS      +: 16] = 16'h0;
        h[HDR_WORD_LEN_POS +: 16] = word_len;
        h[HDR_DST_POS      +: 16] = dst;
        return h;
    endfunction

endpackage

// File: rtl/stat_report_sched_arb.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any
);
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
            idx = sum[PW-1:0];
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stat_report_sched_fifo.sv
// Small first-word-fallthrough FIFO: the head entry is visible on dout whenever !empty.
// nearly_full leaves one free slot so the upstream can stop with a word already in flight.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             nearly_full
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]        mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      full, wr_ok, rd_ok;

    assign full        = (depth == (MAX_DEPTH_BITS+1)'(DEPTH));
    assign empty       = (depth == '0);
    assign nearly_full = (depth >= (MAX_DEPTH_BITS+1)'(DEPTH-1));
    assign dout        = mem[rd_ptr];
    assign wr_ok       = wr_en && !full;
    assign rd_ok       = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   depth <= depth + 1'b1;
                2'b01:   depth <= depth - 1'b1;
                default: depth <= depth;
            endcase
        end
    end

endmodule

// File: rtl/stat_report_sched.sv
// Merges fixed-length RTT timestamp reports from per-CPU time_fifos into the forwarded stream,
// only at packet boundaries. Handshake: a word transfers in any cycle where out_wr is high;
// out_wr is only raised while out_rdy is high, combinationally in the same cycle.
module stat_report_sched
    import stat_report_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_SRC    = 2,
    parameter int RPT_WORDS  = 16,
    parameter int TMO_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [CTRL_WIDTH-1:0]   in_ctrl,
    input  logic                    in_wr,
    output logic                    in_rdy,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [CTRL_WIDTH-1:0]   out_ctrl,
    output logic                    out_wr,
    input  logic                    out_rdy,
    input  logic [NUM_SRC*64-1:0]   stat_dout,
    input  logic [NUM_SRC-1:0]      stat_empty,
    input  logic [NUM_SRC-1:0]      stat_full,
    output logic [NUM_SRC-1:0]      stat_rd_en,
    input  logic [TMO_WIDTH-1:0]    cfg_timeout,
    input  logic [NUM_SRC-1:0]      sw_flush,
    output logic [31:0]             rpt_count
);
    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int FW    = CTRL_WIDTH + DATA_WIDTH;

    state_t state, state_next;

    logic [FW-1:0]         fifo_dout;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic [CTRL_WIDTH-1:0] fifo_ctrl;
    logic                  fifo_empty, fifo_nearly_full, fifo_rd;

    logic [NUM_SRC-1:0]    pending, set_evt, grant, arb_grant;
    logic [TMO_WIDTH-1:0]  age [NUM_SRC];
    logic [PTR_W-1:0]      rr_ptr, g_idx, arb_idx;
    logic                  arb_any, thru_first;
    logic [7:0]            word_cnt;
    logic [63:0]           sel_dout, hdr_word;
    logic [15:0]           hdr_dst;

    fallthrough_small_fifo #(.WIDTH(FW), .MAX_DEPTH_BITS(2)) u_in_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         ({in_ctrl, in_data}),
        .wr_en       (in_wr),
        .rd_en       (fifo_rd),
        .dout        (fifo_dout),
        .empty       (fifo_empty),
        .nearly_full (fifo_nearly_full)
    );

    assign in_rdy    = !fifo_nearly_full;
    assign fifo_data = fifo_dout[DATA_WIDTH-1:0];
    assign fifo_ctrl = fifo_dout[FW-1:DATA_WIDTH];

    rr_arbiter #(.N(NUM_SRC), .PW(PTR_W)) u_arb (
        .req       (pending),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // A set event coinciding with the grant is dropped; full/age will raise it again later.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            set_evt[i] = stat_full[i] || sw_flush[i] ||
                         ((cfg_timeout != '0) && (age[i] == cfg_timeout));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            for (int i = 0; i < NUM_SRC; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant[i])        pending[i] <= 1'b0;
                else if (set_evt[i]) pending[i] <= 1'b1;

                if (grant[i] || stat_empty[i])
                    age[i] <= '0;
                else if (!pending[i] && (age[i] != {TMO_WIDTH{1'b1}}))
                    age[i] <= age[i] + 1'b1;
            end
        end
    end

    assign sel_dout = stat_dout[64*g_idx +: 64];
    assign hdr_dst  = 16'd1 << {g_idx, 1'b1};
    assign hdr_word = make_hdr(16'(RPT_WORDS * 8), 16'(RPT_WORDS), hdr_dst);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        out_wr     = 1'b0;
        out_data   = '0;
        out_ctrl   = '0;
        stat_rd_en = '0;
        fifo_rd    = 1'b0;
        grant      = '0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    grant      = arb_grant;
                    state_next = RPT_HDR;
                end else if (!fifo_empty) begin
                    state_next = THRU;
                end
            end
            THRU: begin
                if (!fifo_empty && out_rdy) begin
                    out_wr   = 1'b1;
                    out_data = fifo_data;
                    out_ctrl = fifo_ctrl;
                    fifo_rd  = 1'b1;
                    if (!thru_first && (fifo_ctrl != '0)) state_next = IDLE;
                end
            end
            RPT_HDR: begin
                if (out_rdy) begin
                    out_wr     = 1'b1;
                    out_ctrl   = CTRL_WIDTH'(IO_QUEUE_STAGE_NUM);
                    out_data   = DATA_WIDTH'(hdr_word);
                    state_next = RPT_DATA;
                end
            end
            RPT_DATA: begin
                if (out_rdy) begin
                    out_wr = 1'b1;
                    if (!stat_empty[g_idx]) begin
                        out_data          = DATA_WIDTH'(sel_dout);
                        stat_rd_en[g_idx] = 1'b1;
                    end else begin
                        out_data = DATA_WIDTH'(PAD_WORD);
                    end
                    if (word_cnt == 8'(RPT_WORDS - 1)) state_next = RPT_END;
                end
            end
            RPT_END: begin
                if (out_rdy) begin
                    out_wr     = 1'b1;
                    out_ctrl   = CTRL_WIDTH'(EOP_CTRL);
                    out_data   = DATA_WIDTH'({32'h0, rpt_count});
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            g_idx      <= '0;
            rr_ptr     <= '0;
            word_cnt   <= '0;
            rpt_count  <= '0;
            thru_first <= 1'b0;
        end else begin
            if (state == IDLE && arb_any) begin
                g_idx  <= arb_idx;
                rr_ptr <= (arb_idx == PTR_W'(NUM_SRC - 1)) ? '0 : arb_idx + 1'b1;
            end
            // The first word of a forwarded packet carries a header ctrl, not an EOP marker.
            if (state == IDLE)  thru_first <= 1'b1;
            else if (fifo_rd)   thru_first <= 1'b0;
            if (state == RPT_HDR)                 word_cnt <= '0;
            else if (state == RPT_DATA && out_rdy) word_cnt <= word_cnt + 1'b1;
            if (state == RPT_END && out_rdy) rpt_count <= rpt_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_stat_report_sched.sv
// Bench for stat_report_sched: models two time_fifo sources, drives packets and flush
// triggers, and checks the merged output stream against a report-level reference model.
module tb_stat_report_sched;
    localparam int NSRC = 2;
    localparam int RPT  = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  in_data;
    logic [7:0]   in_ctrl;
    logic         in_wr;
    logic         in_rdy;
    logic [63:0]  out_data;
    logic [7:0]   out_ctrl;
    logic         out_wr;
    logic         out_rdy = 1'b1;
    logic [127:0] stat_dout = '0;
    logic [1:0]   stat_empty = 2'b11;
    logic [1:0]   stat_full;
    logic [1:0]   stat_rd_en;
    logic [15:0]  cfg_timeout;
    logic [1:0]   sw_flush;
    logic [31:0]  rpt_count;

    stat_report_sched #(
        .DATA_WIDTH(64), .CTRL_WIDTH(8), .NUM_SRC(NSRC), .RPT_WORDS(RPT), .TMO_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .stat_dout(stat_dout), .stat_empty(stat_empty), .stat_full(stat_full),
        .stat_rd_en(stat_rd_en), .cfg_timeout(cfg_timeout), .sw_flush(sw_flush),
        .rpt_count(rpt_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bench state ----------------
    logic [71:0] exp_q[$];
    logic [63:0] src_q[NSRC][$];
    logic [63:0] wr_q[NSRC][$];
    logic [63:0] mdl_q[NSRC][$];
    logic [1:0]  pop_flag = '0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          rdy_mode = 0;
    int          rpt_model = 0;
    int          rr_model = 0;
    int          last_hdr_cyc = 0;
    logic [7:0]  pkt_c[16];
    logic [63:0] pkt_d[16];

    task automatic check(input string nm, input logic [71:0] act, input logic [71:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference model: a report is header, the first RPT words queued at flush time
    // (pad words when the source runs dry), then an EOP word carrying the report number.
    function automatic void push_report(input int s);
        logic [63:0] hdr;
        hdr = {16'(RPT * 8), 16'h0, 16'(RPT), 16'(1 << (2 * s + 1))};
        exp_q.push_back({8'hFF, hdr});
        for (int k = 0; k < RPT; k++) begin
            if (mdl_q[s].size() > 0) exp_q.push_back({8'h00, mdl_q[s].pop_front()});
            else                     exp_q.push_back({8'h00, 64'hFFFF_FFFF_FFFF_FFFF});
        end
        exp_q.push_back({8'h80, 32'h0, 32'(rpt_model)});
        rpt_model++;
        rr_model = (s + 1) % NSRC;
    endfunction

    function automatic void push_pair();
        int start;
        start = rr_model;
        for (int k = 0; k < NSRC; k++) push_report((start + k) % NSRC);
    endfunction

    function automatic void load(input int s, input int n);
        logic [63:0] w;
        for (int k = 0; k < n; k++) begin
            w = {$urandom, $urandom};
            wr_q[s].push_back(w);
            mdl_q[s].push_back(w);
        end
    endfunction

    function automatic void make_pkt(input int len, input logic [7:0] eop);
        for (int k = 0; k < len; k++) begin
            pkt_d[k] = {$urandom, $urandom};
            pkt_c[k] = (k == 0) ? 8'hFF : ((k == len - 1) ? eop : 8'h00);
            exp_q.push_back({pkt_c[k], pkt_d[k]});
        end
    endfunction

    // ---------------- time_fifo source model ----------------
    always @(negedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (pop_flag[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (wr_q[i].size() > 0) src_q[i].push_back(wr_q[i].pop_front());
            stat_dout[64*i +: 64] = (src_q[i].size() > 0) ? src_q[i][0] : 64'h0;
            stat_empty[i]         = (src_q[i].size() == 0);
        end
        pop_flag = '0;
    end

    always @(negedge clk) begin
        case (rdy_mode)
            1:       out_rdy = ($urandom_range(0, 3) != 0);
            2:       out_rdy = ~out_rdy;
            default: out_rdy = 1'b1;
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    always begin
        @(posedge clk);
        #8;
        if (out_wr) begin
            if (out_ctrl == 8'hFF) last_hdr_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_word: got %h required no word (t=%0t)", {out_ctrl, out_data}, $time);
            end else begin
                check("out_word", {out_ctrl, out_data}, exp_q.pop_front());
            end
        end
        if (stat_rd_en != 2'b00) begin
            check("rd_en_onehot", 72'($onehot(stat_rd_en)), 72'(1));
            check("rd_en_with_wr", 72'(out_wr), 72'(1));
            for (int i = 0; i < NSRC; i++) begin
                if (stat_rd_en[i]) begin
                    check("rd_en_nonempty", 72'(stat_empty[i]), 72'(0));
                    pop_flag[i] = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [7:0] c, input logic [63:0] d);
        int g;
        g = 0;
        @(negedge clk);
        in_wr = 1'b0;
        while (!in_rdy && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (!in_rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_rdy_wait: got in_rdy=0 required 1 within 500 cycles");
        end
        in_ctrl = c;
        in_data = d;
        in_wr   = 1'b1;
    endtask

    task automatic drive_pkt(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) send_word(pkt_c[k], pkt_d[k]);
        @(negedge clk);
        in_wr = 1'b0;
    endtask

    task automatic pulse_flush(input logic [1:0] m);
        @(negedge clk);
        sw_flush = m;
        @(negedge clk);
        sw_flush = 2'b00;
    endtask

    task automatic wait_writes();
        int g;
        g = 0;
        while ((wr_q[0].size() != 0 || wr_q[1].size() != 0) && g < 100) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < budget) begin
            @(negedge clk);
            g++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d words outstanding required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish before 500000 ns");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    int t0, d, pre, total, consumed, g, len;

    initial begin
        reset = 1'b1;
        in_data = '0; in_ctrl = '0; in_wr = 1'b0;
        stat_full = '0; cfg_timeout = '0; sw_flush = '0;
        repeat (3) @(negedge clk);
        check("reset_out_wr", 72'(out_wr), 72'(0));
        check("reset_rd_en", 72'(stat_rd_en), 72'(0));
        check("reset_rpt_count", 72'(rpt_count), 72'(0));
        check("reset_in_rdy", 72'(in_rdy), 72'(1));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // packet only
        make_pkt(5, 8'h01);
        drive_pkt(0, 4);
        wait_drain(200);
        check("pkt_only_count", 72'(rpt_count), 72'(0));

        // full-triggered report; two words beyond the quota stay queued
        load(0, 18);
        wait_writes();
        push_report(0);
        @(negedge clk); stat_full = 2'b01;
        @(negedge clk); stat_full = 2'b00;
        wait_drain(300);
        check("full_rpt_count", 72'(rpt_count), 72'(1));
        check("full_leftover", 72'(src_q[0].size()), 72'(mdl_q[0].size()));

        // leftover words plus pad
        push_report(0);
        pulse_flush(2'b01);
        wait_drain(300);

        // age flush from source 1
        cfg_timeout = 16'd100;
        load(1, 3);
        t0 = cyc;
        push_report(1);
        wait_drain(400);
        d = last_hdr_cyc - t0;
        check("age_flush_delay", 72'((d >= 100 && d <= 106) ? 1 : 0), 72'(1));
        cfg_timeout = 16'd0;

        // simultaneous requests, twice
        for (int r = 0; r < 2; r++) begin
            load(0, 4 + r);
            load(1, 6 - r);
            wait_writes();
            push_pair();
            pulse_flush(2'b11);
            wait_drain(600);
        end
        check("pair_rpt_count", 72'(rpt_count), 72'(rpt_model));

        // pending raised mid-packet
        load(1, 2);
        wait_writes();
        make_pkt(6, 8'h04);
        push_report(1);
        send_word(pkt_c[0], pkt_d[0]);
        @(negedge clk); in_wr = 1'b0;
        repeat (3) @(negedge clk);
        pulse_flush(2'b10);
        drive_pkt(1, 5);
        wait_drain(400);

        // randomized mix with random back-pressure
        rdy_mode = 1;
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                len = $urandom_range(2, 10);
                make_pkt(len, 8'($urandom_range(1, 255)));
                drive_pkt(0, len - 1);
            end else begin
                g = $urandom_range(0, NSRC - 1);
                load(g, $urandom_range(0, 15));
                wait_writes();
                push_report(g);
                pulse_flush(2'(1 << g));
            end
            wait_drain(800);
        end
        rdy_mode = 0;
        check("rand_rpt_count", 72'(rpt_count), 72'(rpt_model));

        // toggling out_rdy, reset in the middle of the data phase
        rdy_mode = 2;
        pre = mdl_q[0].size();
        load(0, 10);
        wait_writes();
        push_report(0);
        total = exp_q.size();
        pulse_flush(2'b01);
        g = 0;
        while (exp_q.size() > total - 7 && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("reach_data_phase", 72'((exp_q.size() <= total - 7) ? 1 : 0), 72'(1));
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        rdy_mode = 0;
        consumed = total - exp_q.size();
        exp_q.delete();
        check("post_reset_out_wr", 72'(out_wr), 72'(0));
        check("post_reset_rd_en", 72'(stat_rd_en), 72'(0));
        check("post_reset_rpt_count", 72'(rpt_count), 72'(0));
        repeat (3) @(negedge clk);
        check("reset_pop_count", 72'(src_q[0].size()), 72'(pre + 10 - (consumed - 1)));
        mdl_q[0] = src_q[0];
        rpt_model = 0;
        rr_model = 0;

        // recovery after reset
        push_report(0);
        pulse_flush(2'b01);
        wait_drain(300);
        make_pkt(3, 8'h02);
        drive_pkt(0, 2);
        wait_drain(200);
        check("final_rpt_count", 72'(rpt_count), 72'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
